muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the EX stage, feeding the EX->MEM pipeline register.

---
 rtl/muldiv_unit_pkg.sv | 8 +
 rtl/muldiv_unit_iter_core.sv | 40 ++++
 rtl/muldiv_unit.sv | 95 +++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op and FSM state encodings shared by the multiply/divide unit.
package muldiv_unit_pkg;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10} state_t;
endpackage

// File: rtl/muldiv_unit_iter_core.sv
// muldiv_unit_iter_core: one radix-2 shift-add / restoring shift-subtract step per cycle on unsigned magnitudes.
module muldiv_unit_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);
   logic [WIDTH-1:0] rem, quo, dvs;
   logic             div_q, ge;
   logic [WIDTH:0]   sh, add;
   // rem doubles as the product high half; quo holds the dividend/multiplier and collects result bits
   assign sh     = {rem, quo[WIDTH-1]};
   assign ge     = sh >= {1'b0, dvs};
   assign add    = {1'b0, rem} + {1'b0, quo[0] ? dvs : '0};
   assign nxt_hi = div_q ? (ge ? sh[WIDTH-1:0] - dvs : sh[WIDTH-1:0]) : add[WIDTH:1];
   assign nxt_lo = div_q ? {quo[WIDTH-2:0], ge} : {add[0], quo[WIDTH-1:1]};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         rem   <= '0;
         quo   <= a;
         dvs   <= b;
         div_q <= is_div;
      end else if (step) begin
         rem <= nxt_hi;
         quo <= nxt_lo;
      end
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle EX-stage multiply/divide with stall request, hold and flush.
// Optional single-cycle multiplier when MULDIV_FAST_MUL_EN is defined.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hold,
   input  logic             flush,
   output logic             stall_request,
   output logic             done,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);
   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 div_q, neg_lo, neg_hi;
   logic                 is_div, is_signed, sa, sb, load, step, last, fast;
   logic [WIDTH-1:0]     abs_a, abs_b, core_hi, core_lo, fix_hi, fix_lo;
   logic [2*WIDTH-1:0]   prod, res_nxt;
   assign is_div        = op == OP_DIV || op == OP_DIVU;
   assign is_signed     = op == OP_MULT || op == OP_DIV;
   assign sa            = is_signed && operand_a[WIDTH-1];
   assign sb            = is_signed && operand_b[WIDTH-1];
   assign abs_a         = sa ? -operand_a : operand_a;
   assign abs_b         = sb ? -operand_b : operand_b;
   assign load          = state == ST_IDLE && en && !flush;
   assign step          = state == ST_BUSY && !flush;
   assign last          = step && cnt == CNT_W'(WIDTH - 1);
   assign stall_request = en && state != ST_DONE && !flush;
   assign done          = state == ST_DONE;
   assign prod          = neg_lo ? -{core_hi, core_lo} : {core_hi, core_lo};
   assign fix_hi        = div_q ? (neg_hi ? -core_hi : core_hi) : prod[2*WIDTH-1:WIDTH];
   assign fix_lo        = div_q ? (neg_lo ? -core_lo : core_lo) : prod[WIDTH-1:0];
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a, ext_b;
   assign ext_a   = {{WIDTH{sa}}, operand_a};
   assign ext_b   = {{WIDTH{sb}}, operand_b};
   assign fast    = load && !is_div;
   assign res_nxt = fast ? ext_a * ext_b : {fix_hi, fix_lo};
`else
   assign fast    = 1'b0;
   assign res_nxt = {fix_hi, fix_lo};
`endif
   muldiv_unit_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (is_div),
      .a      (abs_a),
      .b      (abs_b),
      .nxt_hi (core_hi),
      .nxt_lo (core_lo)
   );
   always_comb begin
      state_nxt = state;
      state_nxt = flush ? ST_IDLE :
                  state == ST_IDLE ? (en ? (fast ? ST_DONE : ST_BUSY) : ST_IDLE) :
                  state == ST_BUSY ? (last ? ST_DONE : ST_BUSY) :
                  (hold ? ST_DONE : ST_IDLE);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else state <= state_nxt;
   end
   // divide by zero keeps an all-ones quotient regardless of dividend sign
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         div_q     <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
      end else begin
         if (load) begin
            cnt    <= '0;
            div_q  <= is_div;
            neg_lo <= (sa ^ sb) && !(is_div && operand_b == '0);
            neg_hi <= sa;
         end else if (step) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (fast || last) {result_hi, result_lo} <= res_nxt;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results and latencies.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;
   logic        clk = 1'b0, rst = 1'b0, en = 1'b0, hold = 1'b0, flush = 1'b0;
   logic [1:0]  op = OP_DIVU;
   logic [31:0] operand_a = '0, operand_b = '0;
   logic        stall_request, done;
   logic [31:0] result_hi, result_lo;
   int          n_checks = 0, n_fail = 0;
   int          lat, stalls, mul_lat;

   muldiv_unit dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .op            (op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .hold          (hold),
      .flush         (flush),
      .stall_request (stall_request),
      .done          (done),
      .result_hi     (result_hi),
      .result_lo     (result_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int s);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; en = 1'b1;
      #1;
      s = int'(stall_request);
      l = 0;
      while (!done && l < 100) begin
         @(posedge clk);
         #1;
         l++;
         if (!done) s += int'(stall_request);
      end
   endtask

   task automatic release_en();
      @(negedge clk);
      en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef MULDIV_FAST_MUL_EN
      mul_lat = 1;
`else
      mul_lat = 33;
`endif
      #12;
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(result_hi), 64'd0);
      check("reset_lo", 64'(result_lo), 64'd0);
      check("reset_stall", 64'(stall_request), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      issue(OP_DIVU, 32'd100, 32'd7, lat, stalls);
      check("divu_latency", 64'(lat), 64'd33);
      check("divu_stall_cycles", 64'(stalls), 64'd33);
      check("divu_stall_at_done", 64'(stall_request), 64'd0);
      check("divu_lo", 64'(result_lo), 64'd14);
      check("divu_hi", 64'(result_hi), 64'd2);
      release_en();

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, stalls);
      check("div_neg_lo", 64'(result_lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(result_hi), 64'hFFFF_FFFF);
      release_en();

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls);
      check("div_ovf_lo", 64'(result_lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(result_hi), 64'h0);
      release_en();

      issue(OP_DIVU, 32'd5, 32'd0, lat, stalls);
      check("divu_zero_latency", 64'(lat), 64'd33);
      check("divu_zero_lo", 64'(result_lo), 64'hFFFF_FFFF);
      check("divu_zero_hi", 64'(result_hi), 64'd5);
      release_en();

      issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, stalls);
      check("div_zero_lo", 64'(result_lo), 64'hFFFF_FFFF);
      check("div_zero_hi", 64'(result_hi), 64'hFFFF_FFFB);
      release_en();

      issue(OP_MULT, 32'hFFFF_FFFF, 32'd3, lat, stalls);
      check("mult_latency", 64'(lat), 64'(mul_lat));
      check("mult_stall_cycles", 64'(stalls), 64'(mul_lat));
      check("mult_result", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      release_en();

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls);
      check("multu_max", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
      release_en();

      issue(OP_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFA, lat, stalls);
      check("mult_negneg", {result_hi, result_lo}, 64'd42);
      release_en();

      issue(OP_MULTU, 32'h1234_5678, 32'h10, lat, stalls);
      check("multu_shift", {result_hi, result_lo}, 64'h1_2345_6780);
      release_en();

      // hold in DONE: results frozen, no restart even with en still high
      issue(OP_DIVU, 32'd100, 32'd7, lat, stalls);
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("hold_done", 64'(done), 64'd1);
         check("hold_result", {result_hi, result_lo}, {32'd2, 32'd14});
         check("hold_stall", 64'(stall_request), 64'd0);
      end
      @(negedge clk);
      hold = 1'b0; en = 1'b0;
      @(posedge clk);
      #1;
      check("hold_release_idle", 64'(done), 64'd0);
      issue(OP_DIVU, 32'd1000, 32'd33, lat, stalls);
      check("after_hold_latency", 64'(lat), 64'd33);
      check("after_hold_result", {result_hi, result_lo}, {32'd10, 32'd30});
      release_en();

      // flush mid-divide: back to IDLE, previous result retained
      @(negedge clk);
      op = OP_DIV; operand_a = 32'd50; operand_b = 32'd3; en = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_stall", 64'(stall_request), 64'd0);
      @(posedge clk);
      #1;
      check("flush_done", 64'(done), 64'd0);
      check("flush_keep", {result_hi, result_lo}, {32'd10, 32'd30});
      @(negedge clk);
      flush = 1'b0; en = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("flush_no_finish", 64'(done), 64'd0);
      check("flush_keep_late", {result_hi, result_lo}, {32'd10, 32'd30});

      // async reset mid-BUSY
      @(negedge clk);
      op = OP_DIV; operand_a = 32'd77; operand_b = 32'd5; en = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0; en = 1'b0;
      #1;
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", {result_hi, result_lo}, 64'd0);
      check("rst_stall", 64'(stall_request), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      issue(OP_DIVU, 32'd9, 32'd4, lat, stalls);
      check("post_rst_latency", 64'(lat), 64'd33);
      check("post_rst_result", {result_hi, result_lo}, {32'd1, 32'd2});
      release_en();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
